// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. It holds the PC, fetches words over a req/ack handshake
// and exposes the decoded fields, the zero flag and the condition evaluation.
//
// state   | meaning
// S_FETCH | request outstanding at pc, waiting for imem_ack
// S_HOLD  | instr valid, waiting for stall = 0 to retire
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        selPC,
  input  logic [31:0] branch_target,
  input  logic        flag_we,
  input  logic        flag_zero_in,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [3:0]  condicion,
  output logic [1:0]  operation,
  output logic [5:0]  opcodes,
  output logic        zero,
  output logic        cond_pass,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]  state;
  logic        retire;
  logic [31:0] pc_next;

  assign retire  = (state == S_HOLD) && !stall;
  assign pc_next = selPC ? {branch_target[31:2], 2'b00} : pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      zero        <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (retire) begin
            pc          <= pc_next;
            instr_valid <= 1'b0;
            state       <= S_FETCH;
            if (flag_we) zero <= flag_zero_in;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Gated by rst so the request drops the moment reset asserts.
  assign imem_req  = (state == S_FETCH) && !rst;
  assign imem_addr = pc;

  assign condicion = instr[31:28];
  assign operation = instr[27:26];
  assign opcodes   = instr[25:20];
  assign pc_plus8  = pc + 32'd8;

  always_comb begin
    cond_pass = 1'b0;
    case (condicion)
      4'b1110: cond_pass = 1'b1;
      4'b0000: cond_pass = zero;
      4'b0001: cond_pass = !zero;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule
